// File: rtl/mem_bus_pkg.sv
// Shared types and sizing for the register-bank bus master.
package mem_bus_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int CNT_W       = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    WAIT_LOW = 2'd2,
    RESP     = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response handshakes plus the select/ack register-bank bus.
interface mem_bus_master_if;
  import mem_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              sel_en;
  logic              wr_rd_s;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ack;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, rd_data, ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr, wr_data
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, rd_data, ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr, wr_data
  );

endinterface

// File: rtl/mem_bus_wdog.sv
// Saturating wait counter for the ACCESS / WAIT_LOW phases.
// o_done flags the cycle whose closing edge brings the count to TIMEOUT,
// so a phase lasts exactly TIMEOUT cycles when no response arrives.
module mem_bus_wdog
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count while enabled, restart on phase entry, hold at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TO_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt >= TO_M1);

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding initiator for the register-bank select/ack bus.
// Takes one command on the request port, runs one bus access, waits for
// ack to drop, then presents the result on the response port.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int NUM_OF_REG = 4,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_master_if.master   bif,
  output logic               busy
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_ACCESS   = ACCESS;
  localparam logic [1:0] S_WAIT_LOW = WAIT_LOW;
  localparam logic [1:0] S_RESP     = RESP;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_addr_oor;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_done;

  logic              r_sel_en;
  logic              r_wr_rd_s;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_cap_data;
  logic              r_cap_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  // Next-state decode; ack wins over a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_oor  = (int'(bif.req_addr) >= NUM_OF_REG);
    case (r_state)
      S_IDLE:     if (bif.req_valid) w_state_nxt = w_addr_oor ? S_RESP : S_ACCESS;
      S_ACCESS:   if (bif.ack || w_wd_done) w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: if (!bif.ack || w_wd_done) w_state_nxt = S_RESP;
      S_RESP:     if (bif.rsp_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wd_en  = (r_state == S_ACCESS) || (r_state == S_WAIT_LOW);
  assign w_wd_clr = (w_state_nxt != r_state) &&
                    ((w_state_nxt == S_ACCESS) || (w_state_nxt == S_WAIT_LOW));

  mem_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_wd_clr),
    .i_en   (w_wd_en),
    .o_done (w_wd_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bus drive, access result capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_en    <= 1'b0;
      r_wr_rd_s   <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_cap_data  <= '0;
      r_cap_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bif.req_valid) begin
            if (w_addr_oor) begin
              // Rejected without touching the bus.
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_sel_en   <= 1'b1;
              r_wr_rd_s  <= bif.req_wr;
              r_addr     <= bif.req_addr;
              r_wr_data  <= bif.req_wdata;
              r_cap_data <= '0;
              r_cap_err  <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          if (bif.ack) begin
            r_sel_en   <= 1'b0;
            r_cap_data <= r_wr_rd_s ? '0 : bif.rd_data;
          end else if (w_wd_done) begin
            r_sel_en   <= 1'b0;
            r_cap_data <= '0;
            r_cap_err  <= 1'b1;
          end
        end
        S_WAIT_LOW: begin
          // A stuck-high ack flags an error but keeps any read data already taken.
          if (!bif.ack) begin
            r_rsp_rdata <= r_cap_data;
            r_rsp_err   <= r_cap_err;
          end else if (w_wd_done) begin
            r_rsp_rdata <= r_cap_data;
            r_rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bif.req_ready = (r_state == S_IDLE);
  assign bif.rsp_valid = (r_state == S_RESP);
  assign bif.rsp_rdata = r_rsp_rdata;
  assign bif.rsp_err   = r_rsp_err;
  assign bif.sel_en    = r_sel_en;
  assign bif.wr_rd_s   = r_wr_rd_s;
  assign bif.addr      = r_addr;
  assign bif.wr_data   = r_wr_data;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master against a registered-ack register bank.
module tb_mem_bus_master;

  logic clk;
  logic rst_n;
  logic busy;
  logic ack_en;

  int checks;
  int failures;

  mem_bus_master_if bus();

  mem_bus_master #(.NUM_OF_REG(4), .TIMEOUT(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bus.master),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: ack and rd_data registered one cycle behind sel_en.
  logic [7:0] bank [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack     <= 1'b0;
      bus.rd_data <= 8'h00;
    end else begin
      bus.ack <= bus.sel_en & ack_en;
      if (bus.sel_en && !bus.wr_rd_s) bus.rd_data <= bank[bus.addr[1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.sel_en && bus.wr_rd_s) bank[bus.addr[1:0]] <= bus.wr_data;
  end

  // Bus-contract monitor, sampled mid-cycle.
  int         mon_cyc      = 0;
  int         mon_last_ack = -100;
  int         mon_sel_cnt  = 0;
  int         mon_viol     = 0;
  logic       mon_prev_sel = 1'b0;
  logic [7:0] mon_prev_addr = 8'h00;
  logic [7:0] mon_prev_wd   = 8'h00;
  logic       mon_prev_dir  = 1'b0;

  always @(negedge clk) begin
    mon_cyc = mon_cyc + 1;
    if (bus.sel_en) mon_sel_cnt = mon_sel_cnt + 1;
    if (bus.sel_en && !mon_prev_sel && (mon_cyc - mon_last_ack) < 2) mon_viol = mon_viol + 1;
    if (bus.sel_en && mon_prev_sel &&
        (bus.addr != mon_prev_addr || bus.wr_data != mon_prev_wd || bus.wr_rd_s != mon_prev_dir))
      mon_viol = mon_viol + 1;
    if (bus.ack) mon_last_ack = mon_cyc;
    mon_prev_sel  = bus.sel_en;
    mon_prev_addr = bus.addr;
    mon_prev_wd   = bus.wr_data;
    mon_prev_dir  = bus.wr_rd_s;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, returns result and the cycle (accept = 0) rsp_valid was first seen.
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin tick(); n++; end
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    n   = 0;
    while (!bus.rsp_valid && n < 100) begin tick(); lat++; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL cmd_wait addr=%0h: no rsp_valid within 100 cycles", a);
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.sel_en, bus.wr_rd_s, busy} !== 5'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=00000", {bus.rsp_valid, bus.rsp_err, bus.sel_en, bus.wr_rd_s, busy});
    end
    checks++;
    if ({bus.rsp_rdata, bus.addr, bus.wr_data} !== 24'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=000000", {bus.rsp_rdata, bus.addr, bus.wr_data});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic er; int lat;
    do_cmd(1'b1, 8'd2, 8'hA5, rd, er, lat);
    checks++;
    if ({er, rd} !== 9'h000) begin failures++; $display("FAIL wr_rsp got err=%b rdata=%h exp err=0 rdata=00", er, rd); end
    do_cmd(1'b0, 8'd2, 8'h00, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 8'hA5}) begin failures++; $display("FAIL rd_rsp got err=%b rdata=%h exp err=0 rdata=a5", er, rd); end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd; logic er; int lat; int sel0;
    sel0 = mon_sel_cnt;
    do_cmd(1'b0, 8'd7, 8'h00, rd, er, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL oor_latency got=%0d exp=1", lat); end
    checks++;
    if ({er, rd} !== {1'b1, 8'h00}) begin failures++; $display("FAIL oor_rsp got err=%b rdata=%h exp err=1 rdata=00", er, rd); end
    checks++;
    if (mon_sel_cnt - sel0 !== 0) begin failures++; $display("FAIL oor_sel got=%0d exp=0", mon_sel_cnt - sel0); end
  endtask

  task automatic test_timeout();
    logic [7:0] rd; logic er; int lat; int sel0;
    ack_en = 1'b0;
    sel0 = mon_sel_cnt;
    do_cmd(1'b0, 8'd1, 8'h00, rd, er, lat);
    checks++;
    if (mon_sel_cnt - sel0 !== 16) begin failures++; $display("FAIL to_sel_cycles got=%0d exp=16", mon_sel_cnt - sel0); end
    checks++;
    if ({er, rd} !== {1'b1, 8'h00}) begin failures++; $display("FAIL to_rsp got err=%b rdata=%h exp err=1 rdata=00", er, rd); end
    checks++;
    if ({bus.req_ready, busy} !== 2'b10) begin failures++; $display("FAIL to_idle got ready/busy=%b exp=10", {bus.req_ready, busy}); end
    ack_en = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [7:0] rd; logic er; int lat; int n;
    do_cmd(1'b1, 8'd0, 8'h3C, rd, er, lat);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'd0; bus.req_wdata = 8'h00;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready} !== {1'b1, 8'h3C, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b rdata=%h ready=%b exp valid=1 rdata=3c ready=0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'd2;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept busy got=%b exp=1", busy); end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin tick(); n++; end
    checks++;
    if (bus.rsp_rdata !== 8'hA5) begin failures++; $display("FAIL bp_next_rdata got=%h exp=a5", bus.rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic er; int lat;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'd2;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.sel_en !== 1'b1) begin failures++; $display("FAIL rm_in_access sel_en got=%b exp=1", bus.sel_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sel_en, bus.rsp_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rm_async got sel/valid/busy=%b exp=000", {bus.sel_en, bus.rsp_valid, busy});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", bus.req_ready); end
    do_cmd(1'b0, 8'd2, 8'h00, rd, er, lat);
    checks++;
    if ({er, rd, lat[7:0]} !== {1'b0, 8'hA5, 8'd5}) begin
      failures++;
      $display("FAIL rm_fresh_read got err=%b rdata=%h lat=%0d exp err=0 rdata=a5 lat=5", er, rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int lat; int n; int v0;
    logic [7:0] addrs [3];
    logic [7:0] vals  [3];
    addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd3;
    vals[0]  = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    v0 = mon_viol;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr  = addrs[i];
      bus.req_wdata = vals[i];
      n = 0;
      while (!bus.req_ready && n < 50) begin tick(); n++; end
      tick();
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain busy got=%b exp=0", busy); end
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, addrs[i], 8'h00, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, vals[i]}) begin
        failures++;
        $display("FAIL b2b_readback[%0d] got err=%b rdata=%h exp err=0 rdata=%h", i, er, rd, vals[i]);
      end
    end
    checks++;
    if (mon_viol - v0 !== 0) begin failures++; $display("FAIL bus_contract violations got=%0d exp=0", mon_viol - v0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ack_en   = 1'b1;
    rst_n    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
